// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin AXI4-Stream arbiter: NUM_IN sources merged onto one output, grant held until TLAST.
// Optional per-input completed-packet counters are enabled with `define AXIS_ARB_PKT_CNT_EN.
module axis_rr_arbiter #(
  parameter  int unsigned NUM_IN = 4,
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned DEST_W = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_IN)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_IN-1:0]        s_tvalid,
  output logic [NUM_IN-1:0]        s_tready,
  input  logic [NUM_IN*DATA_W-1:0] s_tdata,
  input  logic [NUM_IN*DEST_W-1:0] s_tdest,
  input  logic [NUM_IN-1:0]        s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [DEST_W-1:0]        m_tdest,
  output logic                     m_tlast,
  output logic [IDX_W-1:0]         grant_idx,
`ifdef AXIS_ARB_PKT_CNT_EN
  output logic [NUM_IN*16-1:0]     pkt_cnt,
`endif
  output logic                     busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_rr_ptr;

  logic              w_found;
  logic [IDX_W-1:0]  w_winner;
  logic              w_active;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic [DATA_W-1:0] w_sel_data;
  logic [DEST_W-1:0] w_sel_dest;
  logic              w_pkt_done;

  // First requester at or after rr_ptr, wrapping modulo NUM_IN.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      int unsigned j;
      j = (32'(r_rr_ptr) + k) % NUM_IN;
      if (!w_found && s_tvalid[j]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'(j);
      end
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_sel_dest  = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (IDX_W'(i) == r_grant) begin
        w_sel_valid = s_tvalid[i];
        w_sel_last  = s_tlast[i];
        w_sel_data  = s_tdata[i*DATA_W +: DATA_W];
        w_sel_dest  = s_tdest[i*DEST_W +: DEST_W];
      end
    end
  end

  // Gating with RST keeps a source from seeing a handshake on the edge that drops ownership.
  assign w_active   = (r_state == ST_BUSY) && !RST;
  assign m_tvalid   = w_active && w_sel_valid;
  assign m_tdata    = w_sel_data;
  assign m_tdest    = w_sel_dest;
  assign m_tlast    = w_sel_last;
  assign w_pkt_done = m_tvalid && m_tready && m_tlast;
  assign grant_idx  = r_grant;
  assign busy       = (r_state == ST_BUSY);

  always_comb begin
    s_tready = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (IDX_W'(i) == r_grant) s_tready[i] = w_active && m_tready;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_BUSY;
            r_grant <= w_winner;
          end
        end
        default: begin
          if (w_pkt_done) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= (r_grant == IDX_W'(NUM_IN - 1)) ? '0 : r_grant + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef AXIS_ARB_PKT_CNT_EN
  logic [NUM_IN-1:0][15:0] r_pkt_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pkt_cnt <= '0;
    end else if (w_pkt_done) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (IDX_W'(i) == r_grant) r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
      end
    end
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (4 inputs, 64-bit data, 2-bit dest).
// Packet-counter checks are included when AXIS_ARB_PKT_CNT_EN is defined.
module tb_axis_rr_arbiter;

  logic         CLK = 1'b0;
  logic         RST;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tready;
  logic [255:0] s_tdata;
  logic [7:0]   s_tdest;
  logic [3:0]   s_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [63:0]  m_tdata;
  logic [1:0]   m_tdest;
  logic         m_tlast;
  logic [1:0]   grant_idx;
  logic         busy;
`ifdef AXIS_ARB_PKT_CNT_EN
  logic [63:0]  pkt_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  axis_rr_arbiter #(.NUM_IN(4), .DATA_W(64), .DEST_W(2)) dut (
    .CLK(CLK), .RST(RST),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tdest(s_tdest), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tdest(m_tdest), .m_tlast(m_tlast),
    .grant_idx(grant_idx),
`ifdef AXIS_ARB_PKT_CNT_EN
    .pkt_cnt(pkt_cnt),
`endif
    .busy(busy)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [63:0] d,
                       input logic [1:0] dest, input logic l);
    s_tvalid[i]          = v;
    s_tdata[i*64 +: 64]  = d;
    s_tdest[i*2 +: 2]    = dest;
    s_tlast[i]           = l;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    s_tvalid = '0; s_tdata = '0; s_tdest = '0; s_tlast = '0;
    m_tready = 1'b1;
    step(); step();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; m_tready = 1'b1;
    s_tvalid = '1; s_tlast = '1; s_tdata = '0; s_tdest = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (s_tready !== 4'b0000) begin bad++; $display("FAIL reset_s_tready c=%0d got=%b exp=0000", c, s_tready); end
      total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid c=%0d got=%b exp=0", c, m_tvalid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy c=%0d got=%b exp=0", c, busy); end
    end
    total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d exp=0", grant_idx); end
    s_tvalid = '0; s_tlast = '0;
    RST = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [63:0] base;
    base = 64'hdeadbeef00000000;
    do_reset();
    drive(2, 1'b1, base, 2'd1, 1'b0);
    #1;
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b exp=0", m_tvalid); end
    step();
    total++; if (grant_idx !== 2'd2 || m_tvalid !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL single_grant got=%0d/%b/%b exp=2/1/1", grant_idx, m_tvalid, busy); end
    for (int k = 0; k < 4; k++) begin
      total++; if (m_tdata !== base + 64'(k)) begin bad++; $display("FAIL single_data k=%0d got=%h exp=%h", k, m_tdata, base + 64'(k)); end
      total++; if (m_tdest !== 2'd1) begin bad++; $display("FAIL single_dest k=%0d got=%0d exp=1", k, m_tdest); end
      total++; if (m_tlast !== (k == 3)) begin bad++; $display("FAIL single_last k=%0d got=%b exp=%b", k, m_tlast, (k == 3)); end
      total++; if (s_tready !== 4'b0100) begin bad++; $display("FAIL single_ready k=%0d got=%b exp=0100", k, s_tready); end
      step();
      if (k < 3) drive(2, 1'b1, base + 64'(k + 1), 2'd1, (k + 1 == 3));
      else       drive(2, 1'b0, '0, 2'd0, 1'b0);
      #1;
    end
    total++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin bad++; $display("FAIL single_end got=%b/%b exp=0/0", busy, m_tvalid); end
    // rr_ptr should now be 3: input 3 beats input 0, then wraps to 0.
    drive(0, 1'b1, 64'h100, 2'd0, 1'b1);
    drive(3, 1'b1, 64'h300, 2'd3, 1'b1);
    step();
    total++; if (grant_idx !== 2'd3 || m_tdata !== 64'h300) begin bad++; $display("FAIL single_rrptr got=%0d/%h exp=3/300", grant_idx, m_tdata); end
    step();
    drive(3, 1'b0, '0, 2'd0, 1'b0);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle2 got=%b exp=0", busy); end
    step();
    total++; if (grant_idx !== 2'd0 || m_tdata !== 64'h100) begin bad++; $display("FAIL single_wrap got=%0d/%h exp=0/100", grant_idx, m_tdata); end
    step();
    drive(0, 1'b0, '0, 2'd0, 1'b0);
    #1;
  endtask

  task automatic test_fairness();
    logic [3:0] bc;
    logic [3:0] hs;
    int g;
    int ph;
    do_reset();
    bc = '0;
    for (int i = 0; i < 4; i++) drive(i, 1'b1, {32'(i), 32'(bc[i])}, 2'(i), bc[i]);
    #1;
    for (int c = 0; c < 24; c++) begin
      ph = c % 3;
      g  = (c / 3) % 4;
      if (ph == 0) begin
        total++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin bad++; $display("FAIL fair_gap c=%0d got=%b/%b exp=0/0", c, busy, m_tvalid); end
      end else begin
        total++; if (grant_idx !== 2'(g)) begin bad++; $display("FAIL fair_grant c=%0d got=%0d exp=%0d", c, grant_idx, g); end
        total++; if (m_tdata !== {32'(g), 32'(ph - 1)}) begin bad++; $display("FAIL fair_data c=%0d got=%h exp=%h", c, m_tdata, {32'(g), 32'(ph - 1)}); end
        total++; if (m_tlast !== (ph == 2)) begin bad++; $display("FAIL fair_last c=%0d got=%b exp=%b", c, m_tlast, (ph == 2)); end
        total++; if (s_tready !== 4'(1 << g)) begin bad++; $display("FAIL fair_ready c=%0d got=%b exp=%b", c, s_tready, 4'(1 << g)); end
      end
      hs = s_tready & s_tvalid;
      step();
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) bc[i] = ~bc[i];
        drive(i, 1'b1, {32'(i), 32'(bc[i])}, 2'(i), bc[i]);
      end
      #1;
    end
    s_tvalid = '0;
    #1;
  endtask

  task automatic test_backpressure();
    int k;
    int got;
    logic hs;
    logic prev_stall;
    logic [63:0] prev_data;
    do_reset();
    k = 0; got = 0; prev_stall = 1'b0; prev_data = '0;
    drive(1, 1'b1, 64'h1100, 2'd2, 1'b0);
    for (int c = 0; c < 40 && got < 8; c++) begin
      m_tready = (c % 2 == 0);
      #1;
      hs = 1'b0;
      if (busy) begin
        total++; if (s_tready !== (m_tready ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL bp_ready c=%0d got=%b mt=%b", c, s_tready, m_tready); end
        total++; if (m_tdata !== 64'h1100 + 64'(k)) begin bad++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, m_tdata, 64'h1100 + 64'(k)); end
        if (prev_stall) begin
          total++; if (m_tdata !== prev_data) begin bad++; $display("FAIL bp_stable c=%0d got=%h exp=%h", c, m_tdata, prev_data); end
        end
        if (m_tvalid && m_tready) begin
          hs = 1'b1; got++;
          total++; if (m_tlast !== (k == 7)) begin bad++; $display("FAIL bp_last k=%0d got=%b exp=%b", k, m_tlast, (k == 7)); end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
      end
      step();
      if (hs) begin
        k++;
        if (k == 8) drive(1, 1'b0, '0, 2'd0, 1'b0);
        else        drive(1, 1'b1, 64'h1100 + 64'(k), 2'd2, (k == 7));
      end
    end
    m_tready = 1'b1;
    #1;
    total++; if (got !== 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", got); end
    total++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin bad++; $display("FAIL bp_end got=%b/%b exp=0/0", busy, m_tvalid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 1'b1, 64'h5000, 2'd0, 1'b0);
    step();
    step(); drive(0, 1'b1, 64'h5001, 2'd0, 1'b0);
    step(); drive(0, 1'b1, 64'h5002, 2'd0, 1'b0);
    #1;
    total++; if (busy !== 1'b1 || m_tdata !== 64'h5002) begin bad++; $display("FAIL mid_pre got=%b/%h exp=1/5002", busy, m_tdata); end
    RST = 1'b1;
    #1;
    total++; if (s_tready !== 4'b0000 || m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_gate got=%b/%b exp=0000/0", s_tready, m_tvalid); end
    step();
    RST = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || grant_idx !== 2'd0 || m_tvalid !== 1'b0) begin
      bad++; $display("FAIL mid_after got=%b/%0d/%b exp=0/0/0", busy, grant_idx, m_tvalid); end
    step();
    for (int k = 2; k < 6; k++) begin
      total++; if (grant_idx !== 2'd0 || m_tvalid !== 1'b1 || m_tdata !== 64'h5000 + 64'(k)) begin
        bad++; $display("FAIL mid_beat k=%0d got=%0d/%b/%h exp=0/1/%h", k, grant_idx, m_tvalid, m_tdata, 64'h5000 + 64'(k)); end
      step();
      if (k < 5) drive(0, 1'b1, 64'h5000 + 64'(k + 1), 2'd0, (k + 1 == 5));
      else       drive(0, 1'b0, '0, 2'd0, 1'b0);
      #1;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_end got=%b exp=0", busy); end
  endtask

`ifdef AXIS_ARB_PKT_CNT_EN
  task automatic test_pkt_cnt();
    do_reset();
    drive(3, 1'b1, 64'h3, 2'd3, 1'b1);
    for (int p = 0; p < 3; p++) begin
      step(); step();
    end
    drive(3, 1'b0, '0, 2'd0, 1'b0);
    drive(0, 1'b1, 64'h0, 2'd0, 1'b1);
    step(); step();
    drive(0, 1'b0, '0, 2'd0, 1'b0);
    #1;
    total++; if (pkt_cnt[63:48] !== 16'd3) begin bad++; $display("FAIL cnt3 got=%0d exp=3", pkt_cnt[63:48]); end
    total++; if (pkt_cnt[15:0] !== 16'd1) begin bad++; $display("FAIL cnt0 got=%0d exp=1", pkt_cnt[15:0]); end
    total++; if (pkt_cnt[47:16] !== 32'd0) begin bad++; $display("FAIL cnt12 got=%h exp=0", pkt_cnt[47:16]); end
  endtask
`endif

  initial begin
    RST = 1'b1;
    m_tready = 1'b1;
    s_tvalid = '0; s_tdata = '0; s_tdest = '0; s_tlast = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
`ifdef AXIS_ARB_PKT_CNT_EN
    test_pkt_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
